// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the MIPS Avalon-MM bus arbiter.
package mips_bus_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT_I = 2'd1,
        ARB_GRANT_D = 2'd2
    } arb_state_t;

    localparam logic [9:0]  ARB_WATCHDOG_LIMIT = 10'd1023;
    localparam logic [31:0] ARB_TIMEOUT_DATA   = 32'hDEAD_BEEF;

endpackage

// File: rtl/mips_bus_arb_pick.sv
// Combinational next-grant selection between the fetch (I) and load/store (D) requesters.
module mips_bus_arb_pick
    import mips_bus_pkg::*;
#(
    parameter int ROUND_ROBIN = 0
) (
    input  logic       req_i,
    input  logic       req_d,
    input  logic       last_d,
    output arb_state_t next_grant
);

    // D wins contention unless alternating priority is on and D was served last.
    always_comb begin
        next_grant = ARB_IDLE;
        if (req_d && (!req_i || (ROUND_ROBIN == 0) || !last_d)) begin
            next_grant = ARB_GRANT_D;
        end else if (req_i) begin
            next_grant = ARB_GRANT_I;
        end
    end

endmodule

// File: rtl/mips_bus_arbiter.sv
// Two-port (fetch / load-store) Avalon-MM arbiter holding a registered grant per transaction.
// Optional stall watchdog and bus_timeout port: define MIPS_BUS_ARB_WATCHDOG_EN.
module mips_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int ROUND_ROBIN = 0,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] i_address,
    input  logic              i_read,
    output logic              i_waitrequest,
    output logic [31:0]       i_readdata,
    input  logic [ADDR_W-1:0] d_address,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [31:0]       d_writedata,
    input  logic [3:0]        d_byteenable,
    output logic              d_waitrequest,
    output logic [31:0]       d_readdata,
    output logic [ADDR_W-1:0] address,
    output logic              read,
    output logic              write,
    output logic [31:0]       writedata,
    output logic [3:0]        byteenable,
    input  logic              waitrequest,
    input  logic [31:0]       readdata,
`ifdef MIPS_BUS_ARB_WATCHDOG_EN
    output logic              bus_timeout,
`endif
    output logic              grant_d,
    output arb_state_t        arb_state
);

    // Handshake: a port command is accepted on the first cycle it is presented while that
    // port's waitrequest is 0; the requester holds address/data/strobes stable until then.
    arb_state_t state;
    arb_state_t pick_grant;
    logic       last_d;
    logic       req_i, req_d, granted_req, bus_wait, done, timeout_hit;

    assign req_i = i_read;
    assign req_d = d_read | d_write;

    mips_bus_arb_pick #(.ROUND_ROBIN(ROUND_ROBIN)) u_pick (
        .req_i      (req_i),
        .req_d      (req_d),
        .last_d     (last_d),
        .next_grant (pick_grant)
    );

    always_comb begin
        granted_req = 1'b0;
        case (state)
            ARB_GRANT_I: granted_req = req_i;
            ARB_GRANT_D: granted_req = req_d;
            default:     granted_req = 1'b0;
        endcase
    end

`ifdef MIPS_BUS_ARB_WATCHDOG_EN
    logic [9:0] stall_cnt;

    assign timeout_hit = granted_req && (stall_cnt == ARB_WATCHDOG_LIMIT);

    // Counts consecutive stalled grant cycles; any non-stall cycle or IDLE clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt   <= '0;
            bus_timeout <= 1'b0;
        end else begin
            if (granted_req && waitrequest && !timeout_hit) begin
                stall_cnt <= stall_cnt + 10'd1;
            end else begin
                stall_cnt <= '0;
            end
            if (timeout_hit) begin
                bus_timeout <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // A watchdog expiry completes the transaction exactly like a real acknowledge.
    assign bus_wait = waitrequest & ~timeout_hit;
    assign done     = granted_req & ~bus_wait;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ARB_IDLE;
            last_d  <= 1'b0;
            grant_d <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    state   <= pick_grant;
                    grant_d <= (pick_grant == ARB_GRANT_D);
                end
                default: begin
                    if (!granted_req || done) begin
                        state   <= ARB_IDLE;
                        grant_d <= 1'b0;
                        if (done) begin
                            last_d <= (state == ARB_GRANT_D);
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        address       = '0;
        read          = 1'b0;
        write         = 1'b0;
        writedata     = '0;
        byteenable    = '0;
        i_waitrequest = 1'b1;
        d_waitrequest = 1'b1;
        case (state)
            ARB_GRANT_I: begin
                address       = i_address;
                read          = i_read;
                byteenable    = 4'b1111;
                i_waitrequest = bus_wait;
            end
            ARB_GRANT_D: begin
                address       = d_address;
                read          = d_read;
                write         = d_write;
                writedata     = d_writedata;
                byteenable    = d_byteenable;
                d_waitrequest = bus_wait;
            end
            default: ;
        endcase
    end

    assign i_readdata = (timeout_hit && state == ARB_GRANT_I) ? ARB_TIMEOUT_DATA : readdata;
    assign d_readdata = (timeout_hit && state == ARB_GRANT_D) ? ARB_TIMEOUT_DATA : readdata;
    assign arb_state  = state;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Bench for mips_bus_arbiter: fixed-priority and round-robin instances share one stimulus stream.
// Watchdog scenario is included when MIPS_BUS_ARB_WATCHDOG_EN is defined.
module tb_mips_bus_arbiter;
    import mips_bus_pkg::*;

    localparam int AW       = 32;
    localparam int OWN_NONE = 0;
    localparam int OWN_I    = 1;
    localparam int OWN_D    = 2;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // ---------------- shared inputs ----------------
    logic [AW-1:0] i_address, d_address;
    logic          i_read, d_read, d_write, waitrequest;
    logic [31:0]   d_writedata, readdata;
    logic [3:0]    d_byteenable;

    // ---------------- per-instance outputs (0: fixed priority, 1: round robin) ----------------
    logic          o_iwr[2], o_dwr[2], o_read[2], o_write[2], o_gd[2];
    logic [31:0]   o_ird[2], o_drd[2], o_wd[2];
    logic [AW-1:0] o_addr[2];
    logic [3:0]    o_be[2];
    arb_state_t    o_st[2];
`ifdef MIPS_BUS_ARB_WATCHDOG_EN
    logic          o_to[2];
`endif

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mips_bus_arbiter #(.ROUND_ROBIN(g), .ADDR_W(AW)) u_dut (
            .clk           (clk),
            .reset         (reset),
            .i_address     (i_address),
            .i_read        (i_read),
            .i_waitrequest (o_iwr[g]),
            .i_readdata    (o_ird[g]),
            .d_address     (d_address),
            .d_read        (d_read),
            .d_write       (d_write),
            .d_writedata   (d_writedata),
            .d_byteenable  (d_byteenable),
            .d_waitrequest (o_dwr[g]),
            .d_readdata    (o_drd[g]),
            .address       (o_addr[g]),
            .read          (o_read[g]),
            .write         (o_write[g]),
            .writedata     (o_wd[g]),
            .byteenable    (o_be[g]),
            .waitrequest   (waitrequest),
            .readdata      (readdata),
`ifdef MIPS_BUS_ARB_WATCHDOG_EN
            .bus_timeout   (o_to[g]),
`endif
            .grant_d       (o_gd[g]),
            .arb_state     (o_st[g])
        );
    end

    // ---------------- scoreboard bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [0:0] exp_q[$];
    logic       rr_watch = 1'b0;
    logic       prev_idle1 = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Owner of the bus per instance, last served port, stall run length, sticky timeout.
    int m_own[2]   = '{0, 0};
    bit m_last_d[2] = '{0, 0};
    int m_stall[2] = '{0, 0};
    bit m_to[2]    = '{0, 0};

    function automatic bit own_req(input int k);
        if (m_own[k] == OWN_I) return i_read;
        if (m_own[k] == OWN_D) return d_read | d_write;
        return 1'b0;
    endfunction

    function automatic bit timeout_now(input int k);
`ifdef MIPS_BUS_ARB_WATCHDOG_EN
        return own_req(k) && (m_stall[k] == 1023);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_step(input int k);
        bit ri, rd, to;
        ri = i_read;
        rd = d_read | d_write;
        to = timeout_now(k);
        if (m_own[k] == OWN_NONE) begin
            if (rd && (!ri || k == 0 || !m_last_d[k])) m_own[k] = OWN_D;
            else if (ri)                               m_own[k] = OWN_I;
            m_stall[k] = 0;
        end else if (!own_req(k)) begin
            m_own[k]   = OWN_NONE;
            m_stall[k] = 0;
        end else if (!waitrequest || to) begin
            m_last_d[k] = (m_own[k] == OWN_D);
            if (to) m_to[k] = 1'b1;
            m_own[k]   = OWN_NONE;
            m_stall[k] = 0;
        end else begin
            m_stall[k]++;
        end
    endtask

    always @(posedge clk or negedge reset) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset) begin
                m_own[k] = OWN_NONE; m_last_d[k] = 1'b0; m_stall[k] = 0; m_to[k] = 1'b0;
            end else begin
                model_step(k);
            end
        end
    end

    task automatic compare_inst(input int k);
        logic [31:0] e_addr, e_wd, e_ird, e_drd, e_st;
        logic        e_rd, e_wr, e_iwr, e_dwr, e_gd, to;
        logic [3:0]  e_be;
        to = timeout_now(k);
        e_addr = '0; e_wd = '0; e_rd = 1'b0; e_wr = 1'b0; e_be = '0;
        e_iwr = 1'b1; e_dwr = 1'b1; e_gd = 1'b0; e_st = 32'(ARB_IDLE);
        e_ird = readdata; e_drd = readdata;
        if (m_own[k] == OWN_I) begin
            e_addr = i_address; e_rd = i_read; e_be = 4'hF;
            e_iwr = waitrequest && !to; e_st = 32'(ARB_GRANT_I);
            if (to) e_ird = 32'hDEAD_BEEF;
        end else if (m_own[k] == OWN_D) begin
            e_addr = d_address; e_rd = d_read; e_wr = d_write; e_wd = d_writedata;
            e_be = d_byteenable; e_dwr = waitrequest && !to; e_gd = 1'b1; e_st = 32'(ARB_GRANT_D);
            if (to) e_drd = 32'hDEAD_BEEF;
        end
        check($sformatf("address[%0d]", k),       o_addr[k],        e_addr);
        check($sformatf("read[%0d]", k),          32'(o_read[k]),   32'(e_rd));
        check($sformatf("write[%0d]", k),         32'(o_write[k]),  32'(e_wr));
        check($sformatf("writedata[%0d]", k),     o_wd[k],          e_wd);
        check($sformatf("byteenable[%0d]", k),    32'(o_be[k]),     32'(e_be));
        check($sformatf("i_waitrequest[%0d]", k), 32'(o_iwr[k]),    32'(e_iwr));
        check($sformatf("d_waitrequest[%0d]", k), 32'(o_dwr[k]),    32'(e_dwr));
        check($sformatf("grant_d[%0d]", k),       32'(o_gd[k]),     32'(e_gd));
        check($sformatf("arb_state[%0d]", k),     32'(o_st[k]),     e_st);
`ifdef MIPS_BUS_ARB_WATCHDOG_EN
        check($sformatf("bus_timeout[%0d]", k),   32'(o_to[k]),     32'(m_to[k]));
`endif
        if (m_own[k] != OWN_NONE) begin
            check($sformatf("i_readdata[%0d]", k), o_ird[k], e_ird);
            check($sformatf("d_readdata[%0d]", k), o_drd[k], e_drd);
        end
    endtask

    // Single compare process: every cycle out of reset, plus round-robin grant order.
    always @(negedge clk) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) compare_inst(k);
            if (rr_watch && prev_idle1 && o_st[1] != ARB_IDLE) begin
                if (exp_q.size() == 0) check("rr_extra_grant", 32'(o_gd[1]), 32'hFFFF_FFFF);
                else                   check("rr_grant_order", 32'(o_gd[1]), 32'(exp_q.pop_front()));
            end
            prev_idle1 = (o_st[1] == ARB_IDLE);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                         input logic [31:0] da, input logic [31:0] dwd, input logic [3:0] dbe,
                         input logic wr, input logic [31:0] rdata);
        i_read = ir; i_address = ia; d_read = dr; d_write = dw; d_address = da;
        d_writedata = dwd; d_byteenable = dbe; waitrequest = wr; readdata = rdata;
    endtask

    task automatic drive_idle();
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 4'h0, 1'b0, '0);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        drive_idle();
        reset = 1'b0;
        step();
        for (int k = 0; k < 2; k++) begin
            check("rst_read",  32'(o_read[k]),  32'd0);
            check("rst_write", 32'(o_write[k]), 32'd0);
            check("rst_gd",    32'(o_gd[k]),    32'd0);
            check("rst_iwr",   32'(o_iwr[k]),   32'd1);
            check("rst_dwr",   32'(o_dwr[k]),   32'd1);
            check("rst_addr",  o_addr[k],       32'd0);
        end
        reset = 1'b1;
        step();

        // Lone fetch: bus read on the cycle after the request, zero-wait.
        drive(1'b1, 32'hBFC0_0000, 1'b0, 1'b0, '0, '0, 4'h0, 1'b0, 32'hCAFE_0001);
        step();
        check("fetch_read",  32'(o_read[0]), 32'd1);
        check("fetch_addr",  o_addr[0],      32'hBFC0_0000);
        check("fetch_iwr",   32'(o_iwr[0]),  32'd0);
        check("fetch_rdata", o_ird[0],       32'hCAFE_0001);
        check("fetch_be",    32'(o_be[0]),   32'hF);
        step();
        check("fetch_idle_read", 32'(o_read[0]), 32'd0);
        drive_idle();
        step();

        // Contention: D store served first, then I after one IDLE cycle.
        drive(1'b1, 32'h0000_2000, 1'b0, 1'b1, 32'h0000_1000, 32'h1234_5678, 4'b0011, 1'b0, 32'h0);
        step();
        for (int k = 0; k < 2; k++) begin
            check("cont_write", 32'(o_write[k]), 32'd1);
            check("cont_wd",    o_wd[k],         32'h1234_5678);
            check("cont_be",    32'(o_be[k]),    32'h3);
            check("cont_addr",  o_addr[k],       32'h0000_1000);
            check("cont_iwr",   32'(o_iwr[k]),   32'd1);
        end
        step();
        check("cont_dead_cycle", 32'(o_st[0]), 32'(ARB_IDLE));
        d_write = 1'b0;
        step();
        check("cont_i_read", 32'(o_read[0]), 32'd1);
        check("cont_i_addr", o_addr[0],      32'h0000_2000);
        check("cont_i_be",   32'(o_be[0]),   32'hF);
        step();
        drive_idle();
        step();

        // Continuous contention for six transactions: round robin alternates D,I,D,I,D,I.
        for (int n = 0; n < 3; n++) begin
            exp_q.push_back(1'b1);
            exp_q.push_back(1'b0);
        end
        rr_watch = 1'b1;
        drive(1'b1, 32'h0000_4000, 1'b1, 1'b0, 32'h0000_5000, '0, 4'hF, 1'b0, 32'h1111_2222);
        repeat (12) step();
        rr_watch = 1'b0;
        drive_idle();
        check("rr_remaining", 32'(exp_q.size()), 32'd0);
        step();

        // D stalled for five cycles while I waits, then I is granted next.
        drive(1'b1, 32'h0000_6000, 1'b1, 1'b0, 32'h0000_3000, '0, 4'hF, 1'b1, 32'hA5A5_A5A5);
        step();
        for (int n = 0; n < 5; n++) begin
            check("stall_dwr", 32'(o_dwr[0]), 32'd1);
            check("stall_iwr", 32'(o_iwr[0]), 32'd1);
            check("stall_gd",  32'(o_gd[0]),  32'd1);
            step();
        end
        waitrequest = 1'b0;
        #1;
        check("stall_release_dwr", 32'(o_dwr[0]), 32'd0);
        check("stall_release_iwr", 32'(o_iwr[0]), 32'd1);
        check("stall_rdata",       o_drd[0],      32'hA5A5_A5A5);
        step();
        d_read = 1'b0;
        step();
        check("stall_then_i0", 32'(o_st[0]), 32'(ARB_GRANT_I));
        check("stall_then_i1", 32'(o_st[1]), 32'(ARB_GRANT_I));
        step();
        drive_idle();
        step();

        // Withdrawal during a stalled fetch, then D with read and write both high.
        drive(1'b1, 32'h0000_7000, 1'b0, 1'b0, '0, '0, 4'h0, 1'b1, 32'h0);
        step();
        i_read = 1'b0;
        step();
        check("withdraw_idle", 32'(o_st[0]), 32'(ARB_IDLE));
        drive(1'b0, '0, 1'b1, 1'b1, 32'h0000_8000, 32'h0BAD_F00D, 4'b1100, 1'b0, 32'h0);
        step();
        check("rw_both_read",  32'(o_read[0]),  32'd1);
        check("rw_both_write", 32'(o_write[0]), 32'd1);
        check("rw_both_be",    32'(o_be[0]),    32'hC);
        step();
        drive_idle();
        step();

`ifdef MIPS_BUS_ARB_WATCHDOG_EN
        // Permanently stalled fetch: watchdog releases it after 1023 stall cycles.
        begin
            int stalls;
            stalls = 0;
            drive(1'b1, 32'h0000_9000, 1'b0, 1'b0, '0, '0, 4'h0, 1'b1, 32'h0);
            step();
            for (int n = 0; n < 1100 && o_iwr[0]; n++) begin
                stalls++;
                step();
            end
            check("wd_stall_cycles", 32'(stalls),   32'd1023);
            check("wd_iwr",          32'(o_iwr[0]), 32'd0);
            check("wd_rdata",        o_ird[0],      32'hDEAD_BEEF);
            step();
            drive_idle();
            step();
            check("wd_timeout0", 32'(o_to[0]), 32'd1);
            repeat (3) step();
            check("wd_timeout_sticky", 32'(o_to[0]), 32'd1);
            reset = 1'b0;
            #1;
            check("wd_timeout_reset", 32'(o_to[0]), 32'd0);
            step();
            reset = 1'b1;
            step();
        end
`endif

        // Asynchronous reset in the middle of a stalled D write.
        drive(1'b0, '0, 1'b0, 1'b1, 32'h0000_A000, 32'h55AA_55AA, 4'hF, 1'b1, 32'h0);
        step();
        check("async_pre_write", 32'(o_write[0]), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check("async_write", 32'(o_write[k]), 32'd0);
            check("async_read",  32'(o_read[k]),  32'd0);
            check("async_gd",    32'(o_gd[k]),    32'd0);
            check("async_iwr",   32'(o_iwr[k]),   32'd1);
            check("async_dwr",   32'(o_dwr[k]),   32'd1);
            check("async_addr",  o_addr[k],       32'd0);
            check("async_state", 32'(o_st[k]),    32'(ARB_IDLE));
        end
        drive_idle();
        step();
        reset = 1'b1;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Hard time bound so the run always ends.
    initial begin
        #500000;
        n_errors++;
        $display("FAIL sim_time_limit: got %0t expected completion before it", $time);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
